// File: rtl/mul_div_unit_if.sv
// Handshake/bus bundle between the EX stage and the multiply/divide unit.
// Ports: master drives start/op/a/b/flush/wr_hi/wr_lo/wr_data; slave returns
//        busy/done/div_by_zero and the architectural hi/lo registers.
interface mul_div_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, wr_hi, wr_lo, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, wr_hi, wr_lo, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiply / restoring divide unit with HI/LO registers.
// Latency: done pulses WIDTH+1 edges after the accepting edge (1 edge for divide by zero).
// Backpressure: busy stalls the pipeline; start is ignored while busy, flush cancels.
// Ports: clk, reset (async, active-high), bus (mul_div_unit_if.slave):
//        start/op/a/b issue, flush cancel, wr_hi/wr_lo/wr_data MTHI/MTLO,
//        busy/done/div_by_zero status, hi/lo results.
module mul_div_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [WIDTH-1:0]   ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE2  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_1 = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;     // product / quotient must be negated
  logic             rneg_q, rneg_d;   // remainder must be negated
  logic             dbz_q, dbz_d;     // divide by zero captured at issue
  logic [WIDTH-1:0] acc_q, acc_d;     // partial product high half / partial remainder
  logic [WIDTH-1:0] wrk_q, wrk_d;     // multiplier shifting out / dividend->quotient
  logic [WIDTH-1:0] opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_out_q, dbz_out_d;

  // Operand magnitudes; unsigned ops use the raw values.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = bus.op[0] & bus.a[WIDTH-1];
  assign b_neg = bus.op[0] & bus.b[WIDTH-1];
  assign a_mag = a_neg ? (~bus.a + ONE) : bus.a;
  assign b_mag = b_neg ? (~bus.b + ONE) : bus.b;

  // One multiply step: conditionally add, then shift {sum, wrk} right by one.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

  // One restoring divide step. The remainder before the shift is below the
  // divisor, so a successful subtract always fits back into WIDTH bits.
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;
  assign rem_sh  = {acc_q, wrk_q[WIDTH-1]};
  assign rem_ge  = (rem_sh >= {1'b0, opb_q});
  assign rem_sub = rem_sh[WIDTH-1:0] - opb_q;

  // Sign fixup applied in FIN.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fin_hi, fin_lo;
  assign prod     = {acc_q, wrk_q};
  assign prod_fix = neg_q  ? (~prod + ONE2)  : prod;
  assign quo_fix  = neg_q  ? (~wrk_q + ONE)  : wrk_q;
  assign rem_fix  = rneg_q ? (~acc_q + ONE)  : acc_q;

  always_comb begin
    fin_hi = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo = prod_fix[WIDTH-1:0];
    if (dbz_q) begin
      fin_hi = acc_q;            // holds the raw dividend
      fin_lo = {WIDTH{1'b1}};
    end else if (is_div_q) begin
      fin_hi = rem_fix;
      fin_lo = quo_fix;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    dbz_d     = dbz_q;
    acc_d     = acc_q;
    wrk_d     = wrk_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;

    // MTHI/MTLO only while idle; completion writes happen only while busy.
    if (state_q == S_IDLE) begin
      if (bus.wr_hi) hi_d = bus.wr_data;
      if (bus.wr_lo) lo_d = bus.wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          is_div_d = bus.op[1];
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          dbz_d    = bus.op[1] && (bus.b == '0);
          cnt_d    = '0;
          acc_d    = '0;
          if (bus.op[1]) begin
            wrk_d = a_mag;
            opb_d = b_mag;
          end else begin
            wrk_d = b_mag;
            opb_d = a_mag;
          end
          if (bus.op[1] && (bus.b == '0)) begin
            acc_d   = bus.a;
            state_d = S_FIN;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_1;
          if (is_div_q) begin
            acc_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
            wrk_d = {wrk_q[WIDTH-2:0], rem_ge};
          end else begin
            acc_d = mul_sum[WIDTH:1];
            wrk_d = {mul_sum[0], wrk_q[WIDTH-1:1]};
          end
          if (cnt_q == LAST) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!bus.flush) begin
          hi_d      = fin_hi;
          lo_d      = fin_lo;
          done_d    = 1'b1;
          dbz_out_d = dbz_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dbz_q     <= 1'b0;
      acc_q     <= '0;
      wrk_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      dbz_q     <= dbz_d;
      acc_q     <= acc_d;
      wrk_q     <= wrk_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_out_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
